mem_copy_engine: RTL and testbench

Block-copy initiator that drives the single-port 16-bit data memory over its write-enable/address/write-data/read-data interface. It accepts a copy command (source, destination, length) from the control path with a start/busy/done handshake and moves words one at a time using alternating read and write cycles. It sits between the controller and the memory as the memory's only initiator while busy; the controller must not access the memory during that time.

---
 rtl/mem_copy_engine_pkg.sv | 19 +
 rtl/mem_copy_engine_if.sv | 36 +++
 rtl/mem_copy_engine.sv | 114 +++++++++++
 tb/tb_mem_copy_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the block-copy engine and the data memory it drives.
//   MCE_AW    : address width
//   MCE_DW    : data word width
//   MCE_DEPTH : implemented memory words (legal addresses 0..MCE_DEPTH-1)
//   mce_state_e : copy engine state encoding
package mem_copy_engine_pkg;

  localparam int unsigned MCE_AW    = 16;
  localparam int unsigned MCE_DW    = 16;
  localparam int unsigned MCE_DEPTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } mce_state_e;

endpackage : mem_copy_engine_pkg

// File: rtl/mem_copy_engine_if.sv
// Command handshake plus memory bus of the block-copy engine.
//   start/src/dst/len : copy command from the controller
//   busy/done/err     : command status back to the controller
//   mem_en/mem_addr/mem_wdata : memory write enable, address, write data
//   mem_rdata         : memory read data, combinational from mem_addr
// master = copy engine side, slave = controller/memory side.
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned AW = MCE_AW,
  parameter int unsigned DW = MCE_DW
);

  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  start, src, dst, len, mem_rdata,
    output busy, done, err, mem_en, mem_addr, mem_wdata
  );

  modport slave (
    output start, src, dst, len, mem_rdata,
    input  busy, done, err, mem_en, mem_addr, mem_wdata
  );

endinterface : mem_copy_engine_if

// File: rtl/mem_copy_engine.sv
// Block-copy initiator: copies len words from src to dst, ascending, with
// alternating READ/WRITE cycles on a single-port memory.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mem_copy_engine_if.master (command handshake + memory bus)
// All outputs are registers loaded with the value for the state being entered,
// so mem_rdata never reaches an output combinationally.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned DEPTH = MCE_DEPTH
)(
  input  logic               clk,
  input  logic               rst,
  mem_copy_engine_if.master  bus
);

  localparam int unsigned AW = MCE_AW;

  mce_state_e    state;
  logic [AW-1:0] src_r;
  logic [AW-1:0] dst_r;
  logic [AW-1:0] len_r;
  logic [AW-1:0] idx;
  logic          err_q;

  logic [AW:0]   src_end_c;
  logic [AW:0]   dst_end_c;
  logic          reject_c;
  logic [AW-1:0] idx_nxt_c;

  // Range check one bit wider than the address so the sums cannot wrap.
  assign src_end_c = {1'b0, bus.src} + {1'b0, bus.len};
  assign dst_end_c = {1'b0, bus.dst} + {1'b0, bus.len};
  assign reject_c  = (src_end_c > (AW+1)'(DEPTH)) || (dst_end_c > (AW+1)'(DEPTH));
  assign idx_nxt_c = idx + AW'(1);

  // State machine; mem_wdata doubles as the word buffer between READ and WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      src_r         <= '0;
      dst_r         <= '0;
      len_r         <= '0;
      idx           <= '0;
      err_q         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_r    <= bus.src;
            dst_r    <= bus.dst;
            len_r    <= bus.len;
            idx      <= '0;
            err_q    <= 1'b0;
            bus.busy <= 1'b1;
            if (reject_c) begin
              err_q    <= 1'b1;
              state    <= FIN;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (bus.len == '0) begin
              state    <= FIN;
              bus.done <= 1'b1;
            end else begin
              state        <= READ;
              bus.mem_addr <= bus.src;
            end
          end
        end

        READ: begin
          state         <= WRITE;
          bus.mem_wdata <= bus.mem_rdata;
          bus.mem_addr  <= dst_r + idx;
          bus.mem_en    <= 1'b1;
        end

        WRITE: begin
          idx           <= idx_nxt_c;
          bus.mem_en    <= 1'b0;
          bus.mem_wdata <= '0;
          if (idx_nxt_c == len_r) begin
            state        <= FIN;
            bus.mem_addr <= '0;
            bus.done     <= 1'b1;
            bus.err      <= err_q;
          end else begin
            state        <= READ;
            bus.mem_addr <= src_r + idx_nxt_c;
          end
        end

        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a 12-word memory model.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [15:0] mem [0:11];

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge when mem_en.
  assign bus.mem_rdata = (int'(bus.mem_addr) < 12) ? mem[int'(bus.mem_addr)] : 16'h0000;

  always @(posedge clk) begin
    if (bus.mem_en && int'(bus.mem_addr) < 12)
      mem[int'(bus.mem_addr)] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and watch it to completion.
  // done_cyc = cycle after the accept edge where done was seen (-1 on timeout).
  task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         output int done_cyc, output int en_cnt, output int err_seen,
                         output int consec, output int busy_after);
    logic prev_en;
    done_cyc = -1;
    en_cnt   = 0;
    err_seen = 0;
    consec   = 0;
    prev_en  = 1'b0;
    bus.start = 1'b1;
    bus.src   = s;
    bus.dst   = d;
    bus.len   = l;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.mem_en && prev_en) consec = 1;
      prev_en = bus.mem_en;
      if (bus.done) begin
        done_cyc = c;
        err_seen = int'(bus.err);
        break;
      end
    end
    @(negedge clk);
    busy_after = int'(bus.busy);
  endtask

  int dc, ec, er, cs, ba, ndone;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    for (int k = 0; k < 12; k++) mem[k] <= 16'h0000;
    mem[0] <= 16'h1111;
    mem[1] <= 16'h2222;
    mem[2] <= 16'h3333;
    mem[3] <= 16'h4444;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_en",    32'(bus.mem_en), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic copy 0..3 -> 6..9
    run_cmd(16'd0, 16'd6, 16'd4, dc, ec, er, cs, ba);
    chk("t1_done_cyc", 32'(dc), 32'd9);
    chk("t1_en_cnt",   32'(ec), 32'd4);
    chk("t1_err",      32'(er), 32'd0);
    chk("t1_consec",   32'(cs), 32'd0);
    chk("t1_busy_after", 32'(ba), 32'd0);
    chk("t1_mem6", 32'(mem[6]), 32'h1111);
    chk("t1_mem7", 32'(mem[7]), 32'h2222);
    chk("t1_mem8", 32'(mem[8]), 32'h3333);
    chk("t1_mem9", 32'(mem[9]), 32'h4444);

    // Overlap with dst>src: forward propagation of mem[2]
    mem[2] <= 16'h00AA;
    run_cmd(16'd2, 16'd3, 16'd3, dc, ec, er, cs, ba);
    chk("t2_done_cyc", 32'(dc), 32'd7);
    chk("t2_en_cnt",   32'(ec), 32'd3);
    chk("t2_mem3", 32'(mem[3]), 32'h00AA);
    chk("t2_mem4", 32'(mem[4]), 32'h00AA);
    chk("t2_mem5", 32'(mem[5]), 32'h00AA);

    // Source range out of bounds: rejected
    run_cmd(16'd10, 16'd0, 16'd3, dc, ec, er, cs, ba);
    chk("t3_done_cyc", 32'(dc), 32'd1);
    chk("t3_err",      32'(er), 32'd1);
    chk("t3_en_cnt",   32'(ec), 32'd0);
    chk("t3_mem0",     32'(mem[0]), 32'h1111);
    chk("t3_busy_after", 32'(ba), 32'd0);

    // Zero-length command
    run_cmd(16'd1, 16'd5, 16'd0, dc, ec, er, cs, ba);
    chk("t4_done_cyc", 32'(dc), 32'd1);
    chk("t4_err",      32'(er), 32'd0);
    chk("t4_en_cnt",   32'(ec), 32'd0);

    // start held high through a copy: exactly one done, later src change ignored
    ndone = 0;
    bus.start = 1'b1;
    bus.src   = 16'd0;
    bus.dst   = 16'd10;
    bus.len   = 16'd2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.src = 16'd5;
      if (bus.done) begin
        ndone++;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_mem10", 32'(mem[10]), 32'h1111);
    chk("t5_mem11", 32'(mem[11]), 32'h2222);

    // Reset during the WRITE of the second word
    mem[6] <= 16'h0000;
    mem[7] <= 16'h0000;
    mem[8] <= 16'h0000;
    mem[9] <= 16'h0000;
    bus.start = 1'b1;
    bus.src   = 16'd0;
    bus.dst   = 16'd6;
    bus.len   = 16'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_pre_en", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy",  32'(bus.busy), 32'd0);
    chk("t6_done",  32'(bus.done), 32'd0);
    chk("t6_en",    32'(bus.mem_en), 32'd0);
    chk("t6_addr",  32'(bus.mem_addr), 32'd0);
    chk("t6_wdata", 32'(bus.mem_wdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_mem6", 32'(mem[6]), 32'h1111);
    chk("t6_mem7", 32'(mem[7]), 32'h0000);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t6_no_done", 32'(ndone), 32'd0);
    run_cmd(16'd0, 16'd6, 16'd4, dc, ec, er, cs, ba);
    chk("t6_rerun_done_cyc", 32'(dc), 32'd9);
    chk("t6_rerun_mem7", 32'(mem[7]), 32'h2222);
    chk("t6_rerun_mem9", 32'(mem[9]), 32'h00AA);

    // Boundary: dst+len == DEPTH accepted, one more word rejected
    run_cmd(16'd0, 16'd8, 16'd4, dc, ec, er, cs, ba);
    chk("t7_done_cyc", 32'(dc), 32'd9);
    chk("t7_err",      32'(er), 32'd0);
    chk("t7_mem8",  32'(mem[8]),  32'h1111);
    chk("t7_mem11", 32'(mem[11]), 32'h00AA);
    run_cmd(16'd0, 16'd8, 16'd5, dc, ec, er, cs, ba);
    chk("t8_done_cyc", 32'(dc), 32'd1);
    chk("t8_err",      32'(er), 32'd1);
    chk("t8_en_cnt",   32'(ec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_copy_engine
